// File: rtl/coin_encoder.sv
// Coin-slot front end: synchronizes and debounces three raw sensor lines and
// drains captured coin rises as single-cycle codes on y, quarter first.
module coin_encoder #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nickel_in,
  input  logic       dime_in,
  input  logic       quarter_in,
  input  logic       coin_en,
  output logic [1:0] y,
  output logic       coin_valid,
  output logic [2:0] coin_led
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [2:0]    raw;
  logic [2:0]    s1;
  logic [2:0]    s2;
  logic [2:0]    stable;
  logic [CW-1:0] cnt [3];
  logic [2:0]    commit;
  logic [2:0]    rise;
  logic [2:0]    pend;
  logic [2:0]    pend_next;
  logic [2:0]    drain;
  logic [1:0]    y_next;

  // bit order {quarter, dime, nickel} throughout
  assign raw = {quarter_in, dime_in, nickel_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_comb begin
    commit = '0;
    for (int ch = 0; ch < 3; ch++) begin
      commit[ch] = (s2[ch] != stable[ch]) && (cnt[ch] == CNT_LAST);
    end
  end

  // any return to the debounced level restarts the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= '0;
      for (int ch = 0; ch < 3; ch++) begin
        cnt[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        if (s2[ch] == stable[ch]) begin
          cnt[ch] <= '0;
        end else if (commit[ch]) begin
          stable[ch] <= s2[ch];
          cnt[ch]    <= '0;
        end else begin
          cnt[ch] <= cnt[ch] + 1'b1;
        end
      end
    end
  end

  assign rise = commit & s2;

  always_comb begin
    drain  = 3'b000;
    y_next = 2'b00;
    if (pend[2]) begin
      drain  = 3'b100;
      y_next = 2'b11;
    end else if (pend[1]) begin
      drain  = 3'b010;
      y_next = 2'b10;
    end else if (pend[0]) begin
      drain  = 3'b001;
      y_next = 2'b01;
    end
    pend_next = (pend & ~drain) | rise;
    // disabled acceptance flushes anything still queued
    if (!coin_en) begin
      pend_next = 3'b000;
      y_next    = 2'b00;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend       <= '0;
      y          <= 2'b00;
      coin_valid <= 1'b0;
    end else begin
      pend       <= pend_next;
      y          <= y_next;
      coin_valid <= |y_next;
    end
  end

  assign coin_led = stable;

endmodule

// File: tb/tb_coin_encoder.sv
// Self-checking bench for coin_encoder: directed scenarios plus random bouncing
// lines, compared against a sample-window debounce model with a pending-coin set.
module tb_coin_encoder;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       nickel_in;
  logic       dime_in;
  logic       quarter_in;
  logic       coin_en;
  logic [1:0] y;
  logic       coin_valid;
  logic [2:0] coin_led;

  int total = 0;
  int bad   = 0;

  coin_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .nickel_in (nickel_in),
    .dime_in   (dime_in),
    .quarter_in(quarter_in),
    .coin_en   (coin_en),
    .y         (y),
    .coin_valid(coin_valid),
    .coin_led  (coin_led)
  );

  always #5 clk = ~clk;

  // Reference model: a line's debounced level flips once the D raw samples
  // taken 2..D+1 edges ago all disagree with it; coins wait in a set.
  logic [2:0] hist [0:D+1];
  logic [2:0] m_stable;
  logic [2:0] m_pend;
  logic [2:0] m_rise;
  logic [1:0] m_y;
  logic       m_valid;
  int         m_diff;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= D + 1; i++) hist[i] = 3'b000;
      m_stable = 3'b000;
      m_pend   = 3'b000;
      m_y      = 2'b00;
      m_valid  = 1'b0;
    end else begin
      for (int i = D + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {quarter_in, dime_in, nickel_in};
      m_rise = 3'b000;
      for (int c = 0; c < 3; c++) begin
        m_diff = 0;
        for (int k = 2; k <= D + 1; k++) if (hist[k][c] != m_stable[c]) m_diff++;
        if (m_diff == D) begin
          m_stable[c] = ~m_stable[c];
          if (m_stable[c]) m_rise[c] = 1'b1;
        end
      end
      if (!coin_en) begin
        m_y    = 2'b00;
        m_pend = 3'b000;
      end else begin
        if (m_pend[2]) begin m_y = 2'd3; m_pend[2] = 1'b0; end
        else if (m_pend[1]) begin m_y = 2'd2; m_pend[1] = 1'b0; end
        else if (m_pend[0]) begin m_y = 2'd1; m_pend[0] = 1'b0; end
        else m_y = 2'd0;
        m_pend = m_pend | m_rise;
      end
      m_valid = (m_y != 2'd0);
    end
  end

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; nickel_in = 0; dime_in = 0; quarter_in = 0; coin_en = 1'b1;
    @(negedge clk); @(negedge clk);
    total++; if (y !== 2'b00) begin bad++; $display("FAIL reset_y: got %b want 00", y); end
    total++; if (coin_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", coin_valid); end
    total++; if (coin_led !== 3'b000) begin bad++; $display("FAIL reset_led: got %b want 000", coin_led); end
    reset = 1'b0;
    settle(2);
  endtask

  // Edge numbering: the line changes at the negedge before edge 1.
  task automatic test_clean_nickel;
    nickel_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      total++;
      if ({y, coin_valid, coin_led} !== {m_y, m_valid, m_stable}) begin
        bad++; $display("FAIL nickel_model: y=%b valid=%b led=%b want y=%b valid=%b led=%b", y, coin_valid, coin_led, m_y, m_valid, m_stable);
      end
      total++;
      if (y !== ((i == 7) ? 2'b01 : 2'b00) || coin_valid !== (i == 7)) begin
        bad++; $display("FAIL nickel_pulse edge %0d: y=%b valid=%b", i, y, coin_valid);
      end
      total++;
      if (coin_led[0] !== (i >= 6)) begin
        bad++; $display("FAIL nickel_led edge %0d: got %b want %b", i, coin_led[0], i >= 6);
      end
    end
    nickel_in = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      total++;
      if (y !== 2'b00 || coin_led !== m_stable) begin
        bad++; $display("FAIL nickel_fall edge %0d: y=%b led=%b want 00 %b", i, y, coin_led, m_stable);
      end
    end
  endtask

  task automatic test_bounce;
    int hits;
    for (int i = 0; i < 4; i++) begin
      dime_in = (i % 2 == 0);
      @(negedge clk);
      total++;
      if ({y, coin_valid, coin_led} !== {m_y, m_valid, m_stable}) begin
        bad++; $display("FAIL bounce_model: y=%b valid=%b led=%b want y=%b valid=%b led=%b", y, coin_valid, coin_led, m_y, m_valid, m_stable);
      end
    end
    dime_in = 1'b1;
    hits = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (y == 2'b10) hits++;
      total++;
      if ({y, coin_valid, coin_led} !== {m_y, m_valid, m_stable}) begin
        bad++; $display("FAIL bounce_model: y=%b valid=%b led=%b want y=%b valid=%b led=%b", y, coin_valid, coin_led, m_y, m_valid, m_stable);
      end
      total++;
      if (y !== ((i == 7) ? 2'b10 : 2'b00)) begin
        bad++; $display("FAIL bounce_pulse edge %0d: y=%b", i, y);
      end
    end
    total++; if (hits != 1) begin bad++; $display("FAIL bounce_count: got %0d want 1", hits); end
    dime_in = 1'b0;
    settle(12);
  endtask

  task automatic test_simultaneous;
    logic [1:0] exp_y;
    {quarter_in, dime_in, nickel_in} = 3'b111;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      exp_y = (i == 7) ? 2'b11 : (i == 8) ? 2'b10 : (i == 9) ? 2'b01 : 2'b00;
      total++;
      if ({y, coin_valid, coin_led} !== {m_y, m_valid, m_stable}) begin
        bad++; $display("FAIL simul_model: y=%b valid=%b led=%b want y=%b valid=%b led=%b", y, coin_valid, coin_led, m_y, m_valid, m_stable);
      end
      total++;
      if (y !== exp_y || coin_valid !== (exp_y != 2'b00)) begin
        bad++; $display("FAIL simul_seq edge %0d: y=%b valid=%b want %b", i, y, coin_valid, exp_y);
      end
    end
    {quarter_in, dime_in, nickel_in} = 3'b000;
    settle(12);
  endtask

  task automatic test_coin_en_low;
    int hits;
    coin_en = 1'b0;
    quarter_in = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      total++;
      if (y !== 2'b00 || coin_valid !== 1'b0) begin
        bad++; $display("FAIL en_low_y edge %0d: y=%b valid=%b want 00 0", i, y, coin_valid);
      end
      total++;
      if (coin_led[2] !== (i >= 6)) begin
        bad++; $display("FAIL en_low_led edge %0d: got %b want %b", i, coin_led[2], i >= 6);
      end
    end
    quarter_in = 1'b0;
    settle(10);
    coin_en = 1'b1;
    settle(2);
    {quarter_in, dime_in, nickel_in} = 3'b111;
    hits = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (y != 2'b00) hits++;
      total++;
      if ({y, coin_valid, coin_led} !== {m_y, m_valid, m_stable}) begin
        bad++; $display("FAIL en_flush_model: y=%b valid=%b led=%b want y=%b valid=%b led=%b", y, coin_valid, coin_led, m_y, m_valid, m_stable);
      end
      total++;
      if (y !== ((i == 7) ? 2'b11 : 2'b00)) begin
        bad++; $display("FAIL en_flush_y edge %0d: y=%b", i, y);
      end
      if (i == 7) coin_en = 1'b0;
      if (i == 10) coin_en = 1'b1;
    end
    total++; if (hits != 1) begin bad++; $display("FAIL en_flush_count: got %0d want 1", hits); end
    {quarter_in, dime_in, nickel_in} = 3'b000;
    settle(12);
  endtask

  task automatic test_mid_reset;
    quarter_in = 1'b1;
    settle(10);
    nickel_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({y, coin_valid, coin_led} !== {m_y, m_valid, m_stable}) begin
        bad++; $display("FAIL mid_reset_model: y=%b valid=%b led=%b want y=%b valid=%b led=%b", y, coin_valid, coin_led, m_y, m_valid, m_stable);
      end
    end
    #2 reset = 1'b1;
    #1;
    total++; if (coin_led !== 3'b000) begin bad++; $display("FAIL async_reset_led: got %b want 000", coin_led); end
    total++; if (y !== 2'b00 || coin_valid !== 1'b0) begin bad++; $display("FAIL async_reset_y: y=%b valid=%b", y, coin_valid); end
    @(negedge clk);
    nickel_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      total++;
      if ({y, coin_valid, coin_led} !== {m_y, m_valid, m_stable}) begin
        bad++; $display("FAIL release_model: y=%b valid=%b led=%b want y=%b valid=%b led=%b", y, coin_valid, coin_led, m_y, m_valid, m_stable);
      end
      total++;
      if (y !== ((i == 7) ? 2'b11 : 2'b00)) begin
        bad++; $display("FAIL release_code edge %0d: y=%b", i, y);
      end
    end
    quarter_in = 1'b0;
    settle(12);
  endtask

  task automatic test_reinsert;
    int hits = 0;
    for (int phase = 0; phase < 4; phase++) begin
      nickel_in = (phase % 2 == 0);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (y == 2'b01) hits++;
        total++;
        if ({y, coin_valid, coin_led} !== {m_y, m_valid, m_stable}) begin
          bad++; $display("FAIL reinsert_model: y=%b valid=%b led=%b want y=%b valid=%b led=%b", y, coin_valid, coin_led, m_y, m_valid, m_stable);
        end
      end
    end
    total++; if (hits != 2) begin bad++; $display("FAIL reinsert_count: got %0d want 2", hits); end
  endtask

  task automatic test_random;
    int coins = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      total++;
      if ({y, coin_valid, coin_led} !== {m_y, m_valid, m_stable}) begin
        bad++; $display("FAIL random_model cycle %0d: y=%b valid=%b led=%b want y=%b valid=%b led=%b", i, y, coin_valid, coin_led, m_y, m_valid, m_stable);
      end
      if (y != 2'b00) coins++;
      if ($urandom_range(0, 11) == 0) nickel_in = ~nickel_in;
      if ($urandom_range(0, 11) == 0) dime_in = ~dime_in;
      if ($urandom_range(0, 11) == 0) quarter_in = ~quarter_in;
      if ($urandom_range(0, 63) == 0) coin_en = ~coin_en;
    end
    total++; if (coins == 0) begin bad++; $display("FAIL random_activity: got 0 coins want >0"); end
    {quarter_in, dime_in, nickel_in} = 3'b000;
    coin_en = 1'b1;
    settle(12);
  endtask

  initial begin
    test_reset;
    test_clean_nickel;
    test_bounce;
    test_simultaneous;
    test_coin_en_low;
    test_mid_reset;
    test_reinsert;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
